// File: rtl/camera_dvp_tx_pkg.sv
// camera_dvp_tx_pkg: shared FSM states, pattern codes and RGB565 colour bar constants
package camera_dvp_tx_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT} state_t;
   typedef enum logic [1:0] {PAT_COLUMN, PAT_ROW, PAT_BARS, PAT_ONES} pattern_t;
   localparam logic [15:0] WHITE   = 16'hFFFF;
   localparam logic [15:0] YELLOW  = 16'hFFE0;
   localparam logic [15:0] CYAN    = 16'h07FF;
   localparam logic [15:0] GREEN   = 16'h07E0;
   localparam logic [15:0] MAGENTA = 16'hF81F;
   localparam logic [15:0] RED     = 16'hF800;
   localparam logic [15:0] BLUE    = 16'h001F;
   localparam logic [15:0] BLACK   = 16'h0000;
   localparam logic [7:0][15:0] BARS = {BLACK, BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE};
endpackage

// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen: maps pattern, pixel position and byte select to the DVP data byte
module dvp_pattern_gen import camera_dvp_tx_pkg::*; #(
   parameter int H_ACTIVE = 640
) (
   input  pattern_t   pattern,
   input  logic [9:0] column,
   input  logic [9:0] row,
   input  logic       sel,
   output logic [7:0] d
);
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE >= 8 ? H_ACTIVE / 8 : 1);
   logic [9:0]  bar;
   logic [15:0] px;
   // build the RGB565 pixel, then send the high byte first and the low byte second
   always_comb begin
      bar = column / BAR_W;
      px  = pattern == PAT_COLUMN ? {6'b0, column} :
            pattern == PAT_ROW    ? {6'b0, row} :
            pattern == PAT_BARS   ? BARS[bar > 10'd7 ? 3'd7 : bar[2:0]] : 16'hFFFF;
      d   = sel ? px[7:0] : px[15:8];
   end
endmodule

// File: rtl/camera_dvp_tx.sv
// camera_dvp_tx: DVP camera-style frame transmitter with test patterns
module camera_dvp_tx import camera_dvp_tx_pkg::*; #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 144,
   parameter int VS_LINES = 3,
   parameter int V_BACK   = 17,
   parameter int V_FRONT  = 10
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       START,
   input  logic [1:0] PATTERN,
   output logic       PCLK,
   output logic       VSYNC,
   output logic       HREF,
   output logic [7:0] D,
   output logic       BUSY,
   output logic       FRAME_DONE
);
   localparam int LINE = 2 * H_ACTIVE + H_BLANK;
   localparam int HW   = $clog2(LINE);
   state_t          state, state_n;
   pattern_t        pattern, pattern_n;
   logic [HW-1:0]   hcnt, hcnt_n;
   logic [9:0]      vcnt, vcnt_n, lines;
   logic            start, advance, line_end, last_line, href_n;
   logic [7:0]      d_n;
   // position of the next PCLK period: taken at frame start or on the PCLK falling edge
   always_comb begin
      start     = state == ST_IDLE && START;
      advance   = state != ST_IDLE && PCLK;
      lines     = state == ST_VSYNC ? 10'(VS_LINES) : state == ST_VBACK ? 10'(V_BACK) :
                  state == ST_ACTIVE ? 10'(V_ACTIVE) : 10'(V_FRONT);
      line_end  = hcnt == HW'(LINE - 1);
      last_line = vcnt == lines - 10'd1;
      pattern_n = start ? pattern_t'(PATTERN) : pattern;
      hcnt_n    = start || line_end ? '0 : hcnt + 1'b1;
      vcnt_n    = start || (line_end && last_line) ? '0 : line_end ? vcnt + 10'd1 : vcnt;
      state_n   = start ? ST_VSYNC : !(line_end && last_line) ? state :
                  state == ST_VSYNC ? ST_VBACK : state == ST_VBACK ? ST_ACTIVE :
                  state == ST_ACTIVE ? ST_VFRONT : ST_IDLE;
      href_n    = state_n == ST_ACTIVE && hcnt_n < HW'(2 * H_ACTIVE);
   end
   dvp_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_gen (
      .pattern (pattern_n),
      .column  (10'(hcnt_n >> 1)),
      .row     (vcnt_n),
      .sel     (hcnt_n[0]),
      .d       (d_n)
   );
   // FSM, PCLK divider and registered outputs, updated only when PCLK falls or a frame starts
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state      <= ST_IDLE;
         pattern    <= PAT_COLUMN;
         hcnt       <= '0;
         vcnt       <= '0;
         PCLK       <= 1'b0;
         VSYNC      <= 1'b0;
         HREF       <= 1'b0;
         D          <= 8'h00;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         PCLK       <= state != ST_IDLE && !PCLK;
         FRAME_DONE <= advance && state_n == ST_IDLE;
         if (start || advance) begin
            state   <= state_n;
            pattern <= pattern_n;
            hcnt    <= hcnt_n;
            vcnt    <= vcnt_n;
            VSYNC   <= state_n == ST_VSYNC;
            HREF    <= href_n;
            D       <= href_n ? d_n : 8'h00;
            BUSY    <= state_n != ST_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_camera_dvp_tx.sv
// tb_camera_dvp_tx: randomized frame checks of two camera_dvp_tx instances against a frame model
module tb_camera_dvp_tx;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] start = 2'b00;
   logic [1:0] pattern = 2'd0;
   logic       pclk [2];
   logic       vsync [2];
   logic       href [2];
   logic       busy [2];
   logic       done [2];
   logic [7:0] d [2];
   int         total = 0;
   int         passed = 0;
   localparam logic [15:0] BAR_COLORS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   always #5 clk = ~clk;

   camera_dvp_tx #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(6), .VS_LINES(1), .V_BACK(1), .V_FRONT(1)) dut0 (
      .CLK(clk), .RESETN(resetn), .START(start[0]), .PATTERN(pattern), .PCLK(pclk[0]),
      .VSYNC(vsync[0]), .HREF(href[0]), .D(d[0]), .BUSY(busy[0]), .FRAME_DONE(done[0]));

   camera_dvp_tx #(.H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(6), .VS_LINES(1), .V_BACK(1), .V_FRONT(1)) dut1 (
      .CLK(clk), .RESETN(resetn), .START(start[1]), .PATTERN(pattern), .PCLK(pclk[1]),
      .VSYNC(vsync[1]), .HREF(href[1]), .D(d[1]), .BUSY(busy[1]), .FRAME_DONE(done[1]));

   // expected {VSYNC, HREF, D} for PCLK period i of a frame: line 0 is sync, 1 back porch, 2-3 active, 4 front porch
   function automatic logic [9:0] model(input int k, input int pat, input int i);
      int          ha, line, l, p, col, row;
      logic        h;
      logic [15:0] px;
      ha   = k ? 8 : 4;
      line = 2 * ha + 6;
      l    = i / line;
      p    = i % line;
      col  = p / 2;
      row  = l - 2;
      h    = (l == 2 || l == 3) && p < 2 * ha;
      case (pat)
         0:       px = 16'(col);
         1:       px = 16'(row);
         2:       px = BAR_COLORS[(col / (ha >= 8 ? ha / 8 : 1)) & 7];
         default: px = 16'hFFFF;
      endcase
      return {l == 0, h, h ? (p % 2 == 0 ? px[15:8] : px[7:0]) : 8'h00};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic run_frame(input int k, input int pat, input bit hold);
      logic [9:0] q [$];
      logic       pp, pv, ph;
      logic [7:0] pd;
      bit         got;
      int         line;
      line = k ? 22 : 14;
      pattern = 2'(pat);
      start[k] = 1'b1;
      @(posedge clk); #1;
      if (!hold) start[k] = 1'b0;
      pattern = 2'($urandom);
      check($sformatf("busy_start%0d", k), busy[k], 1);
      pp = pclk[k]; pv = vsync[k]; ph = href[k]; pd = d[k]; got = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
         @(posedge clk); #1;
         if (pclk[k] && !pp) begin
            check("stable_vsync", vsync[k], pv);
            check("stable_href", href[k], ph);
            check("stable_d", d[k], pd);
            q.push_back({vsync[k], href[k], d[k]});
         end
         pp = pclk[k]; pv = vsync[k]; ph = href[k]; pd = d[k];
         got = done[k];
      end
      check($sformatf("frame_done%0d", k), got, 1);
      check($sformatf("periods%0d", k), q.size(), line * 5);
      for (int i = 0; i < q.size(); i++)
         check($sformatf("out_k%0d_p%0d_i%0d", k, pat, i), q[i], model(k, pat, i));
      check("busy_at_done", busy[k], 0);
      check("pclk_at_done", pclk[k], 0);
      @(posedge clk); #1;
      check("done_width", done[k], 0);
      check("busy_after_idle", busy[k], hold);
      if (hold) begin
         start[k] = 1'b0;
         for (int c = 0; c < 2000 && !done[k]; c++) begin
            @(posedge clk); #1;
         end
         check("second_done", done[k], 1);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int  k, p;
      bit  seen;
      repeat (3) @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         check("rst_pclk", pclk[j], 0);
         check("rst_vsync", vsync[j], 0);
         check("rst_href", href[j], 0);
         check("rst_d", d[j], 0);
         check("rst_busy", busy[j], 0);
         check("rst_done", done[j], 0);
      end
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_no_start", busy[0], 0);
      run_frame(0, 0, 1'b0);
      run_frame(1, 2, 1'b0);
      run_frame(0, 1, 1'b1);
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         k = int'($urandom_range(0, 1));
         p = int'($urandom_range(0, 3));
         if (k == 0 && p == 2) p = 3;
         run_frame(k, p, 1'(r == 3));
      end
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      for (int c = 0; c < 500 && !href[0]; c++) begin
         @(posedge clk); #1;
      end
      check("reach_active", href[0], 1);
      resetn = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_pclk", pclk[0], 0);
      check("mid_rst_vsync", vsync[0], 0);
      check("mid_rst_href", href[0], 0);
      check("mid_rst_d", d[0], 0);
      check("mid_rst_busy", busy[0], 0);
      check("mid_rst_done", done[0], 0);
      resetn = 1'b1;
      seen = 1'b0;
      repeat (200) begin
         @(posedge clk); #1;
         seen |= done[0] | busy[0];
      end
      check("no_frame_after_rst", seen, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
